// File: rtl/ifu_fetch.sv
// ifu_fetch -- instruction fetch unit feeding the IF/ID pipeline register.
//
// Owns the PC and issues at most one outstanding request on the instruction
// bus. Returned words are buffered in a DEPTH-entry FIFO, and the FIFO head is
// presented to IF/ID. A jump from the control unit flushes the FIFO and
// redirects the PC. If a request is still in flight when the jump happens, its
// response is dropped when it arrives. Dispatch is stalled by any nonzero
// hold_flag_i.
//
// Optional build macro: IFU_BYPASS_EN
//   When defined, a live response that arrives while the FIFO is empty and
//   dispatch is not held goes straight to inst_*_o in the same cycle. In that
//   case it is not written to the FIFO.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   hold_flag_i[1:0]   nonzero stalls dispatch to IF/ID
//   jump_flag_i        single-cycle redirect + flush
//   jump_addr_i[63:0]  redirect target (low two bits ignored)
//   ibus_req_o         fetch request valid
//   ibus_addr_o[63:0]  fetch address (= PC)
//   ibus_ready_i       bus accepts the request this cycle
//   ibus_rvalid_i      response valid (one per accepted request)
//   ibus_rdata_i[31:0] response instruction word
//   inst_addr_o[63:0]  instruction address to IF/ID (0 when not valid)
//   inst_o[31:0]       instruction to IF/ID (NOP_INST when not valid)
//   inst_valid_o       instruction valid to IF/ID
module ifu_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  hold_flag_i,
  input  logic        jump_flag_i,
  input  logic [63:0] jump_addr_i,
  output logic        ibus_req_o,
  output logic [63:0] ibus_addr_o,
  input  logic        ibus_ready_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [63:0] inst_addr_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C  = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ZERO = {(PTR_W + 1){1'b0}};

  logic [63:0]      pc_q, pc_d;
  logic [63:0]      req_addr_q, req_addr_d;
  logic             outstanding_q, outstanding_d;
  logic             discard_q, discard_d;
  logic             run_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [63:0]      addr_mem_q [DEPTH];
  logic [31:0]      data_mem_q [DEPTH];

  logic           resp_s, keep_s, bypass_s, push_s, pop_s, fifo_valid_s;
  logic           req_s, hs_s;
  logic [PTR_W:0] count_after_s;

  // A response only counts while a request is actually in flight.
  assign resp_s       = ibus_rvalid_i && outstanding_q;
  // A live response survives unless it was marked stale or a jump lands now.
  assign keep_s       = resp_s && !discard_q && !jump_flag_i;
  assign fifo_valid_s = (count_q != CNT_ZERO) && !jump_flag_i;
  assign pop_s        = fifo_valid_s && (hold_flag_i == 2'b00);

`ifdef IFU_BYPASS_EN
  assign bypass_s = keep_s && (count_q == CNT_ZERO) && (hold_flag_i == 2'b00);
`else
  assign bypass_s = 1'b0;
`endif

  assign push_s        = keep_s && !bypass_s;
  assign count_after_s = count_q + (PTR_W + 1)'(push_s) - (PTR_W + 1)'(pop_s);

  // Request gating: issue only with a free slot reserved for the response.
  // A new request may overlap the cycle in which the previous response lands.
  always_comb begin
    req_s = 1'b0;
    if (!run_q || jump_flag_i) begin
      req_s = 1'b0;
    end else if (!outstanding_q) begin
      req_s = (count_q < DEPTH_C);
    end else if (resp_s && !discard_q) begin
      req_s = (count_after_s < DEPTH_C);
    end else begin
      req_s = 1'b0;
    end
  end

  assign hs_s        = req_s && ibus_ready_i;
  assign ibus_req_o  = req_s;
  assign ibus_addr_o = pc_q;

  // Next-state for the PC, the in-flight tracking and the FIFO pointers.
  always_comb begin
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (jump_flag_i) begin
      pc_d = jump_addr_i & ~64'h0000_0000_0000_0003;
    end else if (hs_s) begin
      pc_d = pc_q + 64'd4;
    end else begin
      pc_d = pc_q;
    end

    if (hs_s) begin
      req_addr_d = pc_q;
    end else begin
      req_addr_d = req_addr_q;
    end

    if (hs_s) begin
      outstanding_d = 1'b1;
    end else if (resp_s) begin
      outstanding_d = 1'b0;
    end else begin
      outstanding_d = outstanding_q;
    end

    // Mark the in-flight response stale if a jump overtakes it. A response
    // arriving in the jump cycle is dropped directly, so nothing stays pending.
    if (jump_flag_i && outstanding_q && !ibus_rvalid_i) begin
      discard_d = 1'b1;
    end else if (resp_s) begin
      discard_d = 1'b0;
    end else begin
      discard_d = discard_q;
    end

    if (jump_flag_i) begin
      wr_ptr_d = {PTR_W{1'b0}};
      rd_ptr_d = {PTR_W{1'b0}};
      count_d  = CNT_ZERO;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push_s);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop_s);
      count_d  = count_after_s;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q          <= RESET_PC;
      req_addr_q    <= 64'd0;
      outstanding_q <= 1'b0;
      discard_q     <= 1'b0;
      run_q         <= 1'b0;
      wr_ptr_q      <= {PTR_W{1'b0}};
      rd_ptr_q      <= {PTR_W{1'b0}};
      count_q       <= CNT_ZERO;
    end else begin
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      run_q         <= 1'b1;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // FIFO storage: {request address, instruction word} per entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= 64'd0;
        data_mem_q[i] <= 32'd0;
      end
    end else if (push_s) begin
      addr_mem_q[wr_ptr_q] <= req_addr_q;
      data_mem_q[wr_ptr_q] <= ibus_rdata_i;
    end else begin
      addr_mem_q[wr_ptr_q] <= addr_mem_q[wr_ptr_q];
      data_mem_q[wr_ptr_q] <= data_mem_q[wr_ptr_q];
    end
  end

  // IF/ID view: bypassed response, else FIFO head, else canonical NOP.
  always_comb begin
    inst_valid_o = 1'b0;
    inst_addr_o  = 64'd0;
    inst_o       = NOP_INST;
    if (bypass_s) begin
      inst_valid_o = 1'b1;
      inst_addr_o  = req_addr_q;
      inst_o       = ibus_rdata_i;
    end else if (fifo_valid_s) begin
      inst_valid_o = 1'b1;
      inst_addr_o  = addr_mem_q[rd_ptr_q];
      inst_o       = data_mem_q[rd_ptr_q];
    end else begin
      inst_valid_o = 1'b0;
      inst_addr_o  = 64'd0;
      inst_o       = NOP_INST;
    end
  end

endmodule
